// File: rtl/tpg_pkg.sv
// ============================================================================
// Module      : tpg_pkg
// Description : Shared state encoding and default widths for toggle_pulse_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tpg_pkg;

  localparam int TPG_CNT_W   = 16;
  localparam int TPG_BURST_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tpg_state_e;

endpackage : tpg_pkg

`default_nettype wire

// File: rtl/tpg_down_counter.sv
// ============================================================================
// Module      : tpg_down_counter
// Description : Loadable down-counter with terminal-count flag (value == 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tpg_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             tc
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_val;
    end else if (en) begin
      r_value <= r_value - WIDTH'(1);
    end
  end

  assign value = r_value;
  assign tc    = (r_value == '0);

endmodule : tpg_down_counter

`default_nettype wire

// File: rtl/toggle_pulse_gen.sv
// ============================================================================
// Module      : toggle_pulse_gen
// Description : Programmable-period, optional-burst generator of the one-cycle
//               toggle-enable for a downstream T flip-flop.
//               Optional macro TPG_PULSE_CNT_EN adds the pulse_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_pulse_gen
  import tpg_pkg::*;
#(
  parameter int CNT_W   = TPG_CNT_W,
  parameter int BURST_W = TPG_BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst,
  output logic               t,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef TPG_PULSE_CNT_EN
  ,
  output logic [BURST_W-1:0] pulse_cnt
`endif
);

  tpg_state_e         r_state;
  tpg_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_period;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_left;
  logic               r_t;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_idle_start;
  logic               w_accept;
  logic               w_err_nxt;
  logic               w_pulse;
  logic               w_last;
  logic               w_cnt_load;
  logic [CNT_W-1:0]   w_cnt_load_val;
  logic [CNT_W-1:0]   w_cnt_val;
  logic               w_cnt_tc;

  assign w_idle_start = (r_state == ST_IDLE) && start && !stop;
  assign w_accept     = w_idle_start && (period != '0);
  assign w_err_nxt    = w_idle_start && (period == '0);

  // r_done marks the wind-down cycle after the final pulse: busy still high,
  // no further pulses, then back to IDLE.
  assign w_pulse = (r_state == ST_RUN) && !stop && !r_done && w_cnt_tc;
  assign w_last  = w_pulse && (r_burst != '0) && (r_left == BURST_W'(1));

  assign w_cnt_load     = w_accept || ((r_state == ST_RUN) && (w_cnt_val == '0));
  assign w_cnt_load_val = w_accept ? (period - CNT_W'(1)) : (r_period - CNT_W'(1));

  tpg_down_counter #(
    .WIDTH (CNT_W)
  ) u_period_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (w_cnt_load_val),
    .en       (r_state == ST_RUN),
    .value    (w_cnt_val),
    .tc       (w_cnt_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)         w_state_nxt = ST_RUN;
      ST_RUN:  if (stop || r_done)   w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_t      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_period <= '0;
      r_burst  <= '0;
      r_left   <= '0;
    end else begin
      r_t    <= w_pulse;
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= w_last;
      r_err  <= w_err_nxt;
      if (w_accept) begin
        r_period <= period;
        r_burst  <= burst;
        r_left   <= burst;
      end else if (w_pulse && (r_burst != '0)) begin
        r_left <= r_left - BURST_W'(1);
      end
    end
  end

  assign t    = r_t;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

`ifdef TPG_PULSE_CNT_EN
  logic [BURST_W-1:0] r_pulse_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pulse_cnt <= '0;
    end else if (w_accept) begin
      r_pulse_cnt <= '0;
    end else if (w_pulse) begin
      r_pulse_cnt <= r_pulse_cnt + BURST_W'(1);
    end
  end

  assign pulse_cnt = r_pulse_cnt;
`endif

endmodule : toggle_pulse_gen

`default_nettype wire
